wb_multiport_memory: RTL
========================

// Module: wb_multiport_memory
// PURPOSE
//  Shared word-addressed memory with NUM_PORTS independent Wishbone-classic slave
//  ports, arbitrated round-robin. Generalises the single/dual memory pair of the
//  verification top: adds byte selects, configurable wait states and an error
//  response. Sits below processorci_top in simulation and verification benches.
// PARAMETERS
//  NUM_PORTS    2      number of slave ports (1..8)
//  ADDR_WIDTH   32     byte-address width per port
//  DATA_WIDTH   32     data width per port (32 or 64)
//  MEMORY_SIZE  4096   memory size in bytes (multiple of DATA_WIDTH/8)
//  MEMORY_FILE  ""     $readmemh init file; empty string = no init
//  LATENCY      1      wait cycles between grant and ack (0..15)
// PORTS
//  clk     in   1                     system clock, all logic on rising edge
//  rst_n   in   1                     asynchronous reset, active low
//  cyc_i   in   NUM_PORTS             per-port bus cycle
//  stb_i   in   NUM_PORTS             per-port strobe
//  we_i    in   NUM_PORTS             per-port write enable
//  sel_i   in   NUM_PORTS*DATA_WIDTH/8  per-port byte lane selects
//  addr_i  in   NUM_PORTS*ADDR_WIDTH  per-port byte address (port p = slice p)
//  data_i  in   NUM_PORTS*DATA_WIDTH  per-port write data
//  data_o  out  NUM_PORTS*DATA_WIDTH  per-port read data
//  ack_o   out  NUM_PORTS             per-port acknowledge, 1-cycle pulse
//  err_o   out  NUM_PORTS             per-port error, 1-cycle pulse
// BEHAVIOUR
//  Reset: ack_o=0, err_o=0, data_o=0, FSM=IDLE, last_grant=NUM_PORTS-1 (port 0
//   wins first). Memory array is not cleared by reset.
//  Request of port p: cyc_i[p]&stb_i[p]. Master holds addr/data/we/sel stable until ack/err.
//  FSM: IDLE -> WAIT (LATENCY>0) or RESP (LATENCY=0); WAIT -> RESP after counter
//   hits LATENCY; RESP -> IDLE unconditionally.
//  IDLE: if any request, grant first requesting port searching from
//   last_grant+1 upward with wrap; latch grant index, update last_grant.
//  Timing: request sampled at edge k -> ack/err high during cycle after edge
//   k+LATENCY+1, for exactly one cycle. Min 2 cycles per transaction + LATENCY.
//  Word index = addr >> log2(DATA_WIDTH/8); low address bits ignored.
//  Index >= MEMORY_SIZE/(DATA_WIDTH/8): err_o pulses instead of ack_o, no write,
//   data_o = 0.
//  Write: committed at the RESP edge, only byte lanes with sel_i=1 updated.
//  Read: data_o[p] = full word at index during RESP; data_o for non-acked ports = 0.
//  Abort: granted port drops cyc_i in WAIT -> return to IDLE next edge, no write,
//   no ack/err; last_grant keeps aborted port (it loses priority).
//  Never two ports acked in the same cycle. Same-address writes from two ports are
//   serialised; later grant wins. Ungranted requests wait indefinitely but
//   round-robin bounds wait to (NUM_PORTS-1) transactions.
//  rst_n asserted mid-transaction: outputs to reset values immediately
//   (asynchronously), pending write discarded.
// TESTING
//  1. LATENCY=1, port0 write 0xDEADBEEF @0x10 sel=1111, then read @0x10 -> ack 2 cycles
//     after request, data_o[0]=0xDEADBEEF.
//  2. Port0 write 0xAABBCCDD @0x20 sel=1111, then 0x11223344 sel=0101 -> read 0xAA22CC44.
//  3. Ports 0 and 1 request simultaneously 3 times each -> grants 0,1,0,1,0,1; never
//     both ack_o bits high.
//  4. Read @0x4000 (MEMORY_SIZE=4096) -> err_o pulse, ack_o=0, data_o=0; memory unchanged.
//  5. LATENCY=3, port1 drops cyc in WAIT on write -> no ack/err, later read returns old data.
//  6. rst_n low during WAIT of a write -> ack/err/data_o 0 at once; post-reset read
//     shows unchanged word; next simultaneous request grants port 0.

Source files
------------

// File: rtl/wb_multiport_memory.sv
// Shared word-addressed memory behind NUM_PORTS Wishbone-classic slave ports.
// A round-robin arbiter picks one request at a time. The granted access then
// waits LATENCY cycles and resolves in a single response cycle, which commits
// writes with byte-lane enables. A registered ack/err pulse follows that cycle.
// Out-of-range word indices answer with err instead of ack.
module wb_multiport_memory #(
  parameter int    NUM_PORTS   = 2,
  parameter int    ADDR_WIDTH  = 32,
  parameter int    DATA_WIDTH  = 32,
  parameter int    MEMORY_SIZE = 4096,
  parameter string MEMORY_FILE = "",
  parameter int    LATENCY     = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              cyc_i,
  input  logic [NUM_PORTS-1:0]              stb_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] sel_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   data_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   data_o,
  output logic [NUM_PORTS-1:0]              ack_o,
  output logic [NUM_PORTS-1:0]              err_o
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int OFFSET_BITS = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int DEPTH       = MEMORY_SIZE / BYTES;
  localparam int MEM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW          = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW          = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Storage array; deliberately has no reset so contents survive rst_n.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Sequential state
  state_e                        state_q, state_d;
  logic [GW-1:0]                 grant_q, grant_d;
  logic [GW-1:0]                 last_grant_q, last_grant_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]          ack_q, ack_d;
  logic [NUM_PORTS-1:0]          err_q, err_d;
  logic [NUM_PORTS*DATA_WIDTH-1:0] data_q, data_d;

  // Request / arbitration signals
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] req_eligible;
  logic                 arb_found;
  logic [GW-1:0]        arb_pick;
  int                   cand_int;
  logic [GW-1:0]        cand_idx;

  // Fields of the currently granted port
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic [BYTES-1:0]      g_sel;
  logic                  g_we;
  logic                  g_cyc;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  wr_en;

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;

  // A port that is being acked/erred this cycle is still holding its old
  // request, so it is masked for one cycle to avoid serving it twice.
  always_comb begin
    req          = cyc_i & stb_i;
    req_eligible = req & ~(ack_q | err_q);
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    cand_int  = 0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      cand_int = (int'(last_grant_q) + i) % NUM_PORTS;
      cand_idx = GW'(cand_int);
      if (!arb_found && req_eligible[cand_idx]) begin
        arb_found = 1'b1;
        arb_pick  = cand_idx;
      end
    end
  end

  // Select the granted port's bus fields and decode its word index.
  always_comb begin
    g_addr   = addr_i[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    g_data   = data_i[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    g_sel    = sel_i[int'(grant_q)*BYTES +: BYTES];
    g_we     = we_i[grant_q];
    g_cyc    = cyc_i[grant_q];
    word_idx = g_addr >> OFFSET_BITS;
    in_range = (word_idx < ADDR_WIDTH'(DEPTH));
    mem_idx  = word_idx[MEM_AW-1:0];
    rd_word  = mem[mem_idx];
  end

  // State register plus registered response outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
      cnt_q        <= '0;
      ack_q        <= '0;
      err_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      data_q       <= data_d;
    end
  end

  // Next-state logic: grant in IDLE, count wait states, abort if cyc drops.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d      = arb_pick;
          last_grant_d = arb_pick;
          cnt_d        = CW'(1);
          state_d      = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!g_cyc) begin
          state_d = ST_IDLE;
        end else if (cnt_q >= CW'(LATENCY)) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response generation: decide ack or err, read data and write enable.
  always_comb begin
    ack_d  = '0;
    err_d  = '0;
    data_d = '0;
    wr_en  = 1'b0;
    if (state_q == ST_RESP) begin
      if (in_range) begin
        ack_d[grant_q] = 1'b1;
        wr_en          = g_we;
        if (!g_we) begin
          data_d[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH] = rd_word;
        end
      end else begin
        err_d[grant_q] = 1'b1;
      end
    end
  end

  // Byte-lane write into the array on the response edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (g_sel[b]) begin
          mem[mem_idx][b*8 +: 8] <= g_data[b*8 +: 8];
        end
      end
    end
  end

endmodule
